// File: rtl/rv32_pkg.sv
// Shared RV32 execute-stage definitions: ALU opcodes, M-extension funct3 codes
// and the multiply/divide FSM state type.
package rv32_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } md_state_t;

  // funct3[2] separates the divide group from the multiply group
  function automatic logic md_is_div(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational sign handling for the iterative multiply/divide unit:
// operand magnitudes on the way in, sign restore and half select on the way out.
module muldiv_sign_fix #(
  parameter int XLEN = 32
) (
  input  logic [2:0]        pre_op,
  input  logic [XLEN-1:0]   pre_a,
  input  logic [XLEN-1:0]   pre_b,
  output logic [XLEN-1:0]   mag_a,
  output logic [XLEN-1:0]   mag_b,
  output logic              sgn_a,
  output logic              sgn_b,
  input  logic [2:0]        fix_op,
  input  logic [2*XLEN-1:0] fix_acc,
  input  logic [XLEN-1:0]   fix_rem,
  input  logic              fix_sgn_a,
  input  logic              fix_sgn_b,
  output logic [XLEN-1:0]   fix_result
);
  import rv32_pkg::*;

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot;
  logic [XLEN-1:0]   rem;

  // Sign flags are only raised for operands the opcode treats as signed
  always_comb begin
    sgn_a = 1'b0;
    sgn_b = 1'b0;
    case (pre_op)
      MD_MULH, MD_DIV, MD_REM: begin
        sgn_a = pre_a[XLEN-1];
        sgn_b = pre_b[XLEN-1];
      end
      MD_MULHSU: sgn_a = pre_a[XLEN-1];
      default: ;
    endcase
    mag_a = sgn_a ? -pre_a : pre_a;
    mag_b = sgn_b ? -pre_b : pre_b;
  end

  always_comb begin
    prod = (fix_sgn_a ^ fix_sgn_b) ? -fix_acc : fix_acc;
    quot = (fix_sgn_a ^ fix_sgn_b) ? -fix_acc[XLEN-1:0] : fix_acc[XLEN-1:0];
    rem  = fix_sgn_a ? -fix_rem : fix_rem;
    case (fix_op)
      MD_MUL:                       fix_result = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fix_result = prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              fix_result = quot;
      default:                      fix_result = rem;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle, with a fast path for divide-by-zero and signed overflow.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);
  import rv32_pkg::*;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN);

  md_state_t         state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op_r;
  logic              sgn_a_r, sgn_b_r, fast_r;
  logic [XLEN-1:0]   mag_a_r, mag_b_r;
  logic [2*XLEN-1:0] acc;
  logic [XLEN:0]     rem_r;
  logic [XLEN-1:0]   result_r;
  logic              zero_r;

  logic [XLEN-1:0]   pre_mag_a, pre_mag_b, fix_result, fast_val;
  logic              pre_sgn_a, pre_sgn_b;
  logic              accept, div_zero, div_ovf, fast;
  logic [XLEN:0]     mul_sum, div_shift;
  logic [XLEN+1:0]   div_diff;

  muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .pre_op     (op),
    .pre_a      (src_a),
    .pre_b      (src_b),
    .mag_a      (pre_mag_a),
    .mag_b      (pre_mag_b),
    .sgn_a      (pre_sgn_a),
    .sgn_b      (pre_sgn_b),
    .fix_op     (op_r),
    .fix_acc    (acc),
    .fix_rem    (rem_r[XLEN-1:0]),
    .fix_sgn_a  (sgn_a_r),
    .fix_sgn_b  (sgn_b_r),
    .fix_result (fix_result)
  );

  // Handshakes: a request transfers on a rising edge where in_valid && in_ready
  // && !flush; a result transfers where out_valid && out_ready. Both valids are
  // held by their producers until the transfer; flush discards either side.
  assign accept = in_valid && in_ready && !flush;

  always_comb begin
    div_zero = (src_b == '0);
    div_ovf  = ((op == MD_DIV) || (op == MD_REM)) &&
               (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (src_b == '1);
    fast     = md_is_div(op) && (div_zero || div_ovf);
    fast_val = '0;
    if (div_zero) begin
      fast_val = ((op == MD_DIV) || (op == MD_DIVU)) ? '1 : src_a;
    end else if (div_ovf) begin
      fast_val = (op == MD_DIV) ? src_a : '0;
    end
  end

  // Multiply keeps the multiplier in acc[XLEN-1:0]; divide keeps the dividend
  // there and shifts quotient bits in from the bottom.
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_a_r} : '0);
    div_shift = {rem_r[XLEN-1:0], acc[XLEN-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, mag_b_r};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = CALC;
      CALC:    if (fast_r || (cnt == LAST_ITER)) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      op_r     <= '0;
      sgn_a_r  <= 1'b0;
      sgn_b_r  <= 1'b0;
      fast_r   <= 1'b0;
      mag_a_r  <= '0;
      mag_b_r  <= '0;
      acc      <= '0;
      rem_r    <= '0;
      result_r <= '0;
      zero_r   <= 1'b1;
    end else if (accept) begin
      cnt     <= '0;
      op_r    <= op;
      sgn_a_r <= pre_sgn_a;
      sgn_b_r <= pre_sgn_b;
      fast_r  <= fast;
      mag_a_r <= pre_mag_a;
      mag_b_r <= pre_mag_b;
      acc     <= {{XLEN{1'b0}}, (md_is_div(op) ? pre_mag_a : pre_mag_b)};
      rem_r   <= '0;
      if (fast) begin
        result_r <= fast_val;
        zero_r   <= (fast_val == '0);
      end
    end else if ((state == CALC) && !fast_r) begin
      if (cnt != LAST_ITER) begin
        cnt <= cnt + CNT_W'(1);
        if (md_is_div(op_r)) begin
          rem_r <= div_diff[XLEN+1] ? div_shift : div_diff[XLEN:0];
          acc   <= {acc[2*XLEN-1:XLEN], acc[XLEN-2:0], ~div_diff[XLEN+1]};
        end else begin
          acc <= {mul_sum, acc[XLEN-1:1]};
        end
      end else begin
        result_r <= fix_result;
        zero_r   <= (fix_result == '0);
      end
    end
  end

  assign result = result_r;
  assign zero   = zero_r;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit. It sits beside the single-cycle ALU in the execute stage.
- Accepts operands and a funct3 opcode over a valid/ready handshake and computes the result over multiple cycles.
- Returns the 32-bit result and a zero flag over a second valid/ready handshake.
- The core stalls while `in_ready` is low or a result is pending.

Parameters:
- `XLEN`, 32: operand and result width.
- `CNT_W`, 6: iteration counter width; must satisfy `2^CNT_W > XLEN`.

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  operation request
- `in_ready`  out  1  unit can accept a request
- `op`  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- `src_a`  in  XLEN  rs1 value (multiplicand / dividend)
- `src_b`  in  XLEN  rs2 value (multiplier / divisor)
- `flush`  in  1  synchronous abort of any in-flight operation
- `out_valid`  out  1  result available
- `out_ready`  in  1  consumer takes the result
- `result`  out  XLEN  computed value
- `zero`  out  1  `result == 0`, registered together with `result`

Behaviour:
- Reset (asynchronous, `rst_n` low): state IDLE, `in_ready`=1, `out_valid`=0, `result`=0, `zero`=1, counter=0, all datapath registers 0.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - `in_ready`=1.
  - Request accepted when `in_valid && in_ready`; operands, op and sign flags are latched.
  - Fast path (divide ops only):
    - `src_b`==0 → result loaded directly, go to DONE next cycle. DIV/DIVU quotient = all-ones; REM/REMU remainder = `src_a`.
    - DIV/REM with `src_a`=0x80000000 and `src_b`=0xFFFFFFFF → DIV result 0x80000000, REM result 0; DONE next cycle.
  - Otherwise go to CALC with counter=0.
- CALC (`in_ready`=0):
  - Operands are held as magnitudes. Signed operands are negated if negative:
    - MULH: both operands signed.
    - MULHSU: `src_a` signed only.
    - DIV/REM: both signed.
    - Unsigned ops: no negation.
  - Multiply: shift-add, one multiplier bit per cycle into a 2*XLEN accumulator.
  - Divide: restoring, one quotient bit per cycle. Trial subtract on an XLEN+1-bit partial remainder.
  - Exactly XLEN iterations, then one fix-up cycle:
    - Negate the product if operand signs differ.
    - Negate the quotient if dividend and divisor signs differ (DIV).
    - Remainder takes the dividend's sign (REM).
    - Select the low half (MUL) or high half (MULH*).
  - Then DONE.
- Latency: accept at edge N; normal ops give `out_valid`=1 after edge N+XLEN+1 (33 cycles for XLEN=32); fast path after edge N+1.
- DONE:
  - `out_valid`=1; `result` and `zero` are stable until `out_valid && out_ready`, then go to IDLE.
  - `in_ready`=0 in DONE. No new request is accepted in the handoff cycle; the first accept is the cycle after.
- `flush`:
  - Has priority over every transition except reset.
  - From any state, next state is IDLE and `out_valid` goes to 0. A completed but unconsumed result is discarded.
  - A request presented in the same cycle as `flush` is not accepted.
- `out_ready` held high in DONE: single-cycle handoff. `out_ready` while not `out_valid` is ignored.
- Input changes on `src_a`/`src_b`/`op` after acceptance have no effect.
- All arithmetic is modulo 2^XLEN except the 2*XLEN multiply accumulator and the XLEN+1 divide remainder.
- Reset asserted mid-CALC: immediate return to reset values, no partial result is emitted.

Decomposition:
- Shared package `rv32_pkg`: funct3 encodings `MD_MUL`..`MD_REMU`, FSM state typedef (IDLE/CALC/DONE), `XLEN` constant.
- The ALU opcode constants also move into `rv32_pkg`.
- One sub-module is natural: `muldiv_sign_fix`, a combinational pre-negation and post-negation/half-select helper, reused at input latch and fix-up.
- The FSM, counter and shift datapath stay in `muldiv_unit`.

Test Plan:
- MUL 7 × −3 (0x00000007, 0xFFFFFFFD), `out_ready`=1 → `out_valid` 33 cycles after accept, `result`=0xFFFFFFEB, `zero`=0.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIV 5/0 → 0xFFFFFFFF, REMU 5/0 → 5, DIV 0x80000000/0xFFFFFFFF → 0x80000000. All on the fast path, `out_valid` one cycle after accept.
- Backpressure: `out_ready`=0 for 10 cycles in DONE → `result` stable, `in_ready`=0; then `out_ready`=1 → IDLE next cycle and a new request is accepted.
- `flush` at CALC iteration 15, and separately `rst_n` low at iteration 20 → `out_valid` never asserts; unit returns to IDLE with `in_ready`=1, and the next MUL 3×4 returns 12.
